// File: rtl/sd_cmd_framer.sv
// SD SPI command framer: builds the 6-byte command frame (start bits, CRC7, end bit), streams it
// to the byte engine, then polls with 0xFF fill bytes for R1 and an optional 4-byte R3/R7 payload.
module sd_cmd_framer #(
    parameter int unsigned NCR_MAX = 8
) (
    input  logic        clk50,
    input  logic        rst_n,
    input  logic        cmd_stb,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    input  logic        cmd_long,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  resp_r1,
    output logic [31:0] resp_ext,
    output logic        w_stb,
    output logic [7:0]  w_data,
    input  logic        r_stb,
    input  logic [7:0]  r_data
);

    localparam logic [7:0] NCR_LIMIT = NCR_MAX[7:0];

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CALC      = 4'd1,
        ST_SEND      = 4'd2,
        ST_WAIT_TX   = 4'd3,
        ST_POLL      = 4'd4,
        ST_POLL_WAIT = 4'd5,
        ST_EXT       = 4'd6,
        ST_EXT_WAIT  = 4'd7,
        ST_FINISH    = 4'd8
    } state_t;

    // CRC7 (x^7 + x^3 + 1, init 0) over the 40 header/argument bits, MSB first.
    function automatic logic [6:0] crc7_calc(input logic [39:0] bits);
        logic [6:0] crc;
        logic       fb;
        crc = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb  = bits[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [5:0]  ci,
                                              input logic [31:0] ca,
                                              input logic [6:0]  crc);
        case (idx)
            3'd0:    return {2'b01, ci};
            3'd1:    return ca[31:24];
            3'd2:    return ca[23:16];
            3'd3:    return ca[15:8];
            3'd4:    return ca[7:0];
            3'd5:    return {crc, 1'b1};
            default: return 8'hFF;
        endcase
    endfunction

    state_t      state_r;
    state_t      state_nxt;
    logic [5:0]  cmd_idx_r;
    logic [31:0] cmd_arg_r;
    logic        cmd_long_r;
    logic [6:0]  crc_r;
    logic [2:0]  byte_idx_r;
    logic [2:0]  byte_idx_nxt;
    logic [7:0]  poll_cnt_r;
    logic [7:0]  poll_cnt_nxt;
    logic [1:0]  ext_cnt_r;
    logic [1:0]  ext_cnt_nxt;
    logic        accept_s;
    logic        r1_load_s;
    logic        timeout_set_s;
    logic        ext_shift_s;
    logic        w_stb_nxt;
    logic [7:0]  w_data_nxt;
    logic        busy_r;
    logic        done_r;
    logic        timeout_r;
    logic [7:0]  resp_r1_r;
    logic [31:0] resp_ext_r;
    logic        w_stb_r;
    logic [7:0]  w_data_r;

    // FSM state register.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state, counter and control-strobe decode.
    always_comb begin
        state_nxt     = state_r;
        byte_idx_nxt  = byte_idx_r;
        poll_cnt_nxt  = poll_cnt_r;
        ext_cnt_nxt   = ext_cnt_r;
        accept_s      = 1'b0;
        r1_load_s     = 1'b0;
        timeout_set_s = 1'b0;
        ext_shift_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_stb) begin
                    accept_s     = 1'b1;
                    state_nxt    = ST_CALC;
                    byte_idx_nxt = 3'd0;
                    poll_cnt_nxt = 8'd0;
                    ext_cnt_nxt  = 2'd0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CALC: state_nxt = ST_SEND;
            ST_SEND: state_nxt = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (r_stb) begin
                    if (byte_idx_r == 3'd5) begin
                        state_nxt = ST_POLL;
                    end else begin
                        state_nxt    = ST_SEND;
                        byte_idx_nxt = byte_idx_r + 3'd1;
                    end
                end else begin
                    state_nxt = ST_WAIT_TX;
                end
            end
            ST_POLL: begin
                state_nxt    = ST_POLL_WAIT;
                poll_cnt_nxt = poll_cnt_r + 8'd1;
            end
            ST_POLL_WAIT: begin
                if (r_stb) begin
                    // A cleared MSB marks the R1 byte; anything else is Ncr fill.
                    if (!r_data[7]) begin
                        r1_load_s = 1'b1;
                        state_nxt = cmd_long_r ? ST_EXT : ST_FINISH;
                    end else if (poll_cnt_r < NCR_LIMIT) begin
                        state_nxt = ST_POLL;
                    end else begin
                        timeout_set_s = 1'b1;
                        state_nxt     = ST_FINISH;
                    end
                end else begin
                    state_nxt = ST_POLL_WAIT;
                end
            end
            ST_EXT: state_nxt = ST_EXT_WAIT;
            ST_EXT_WAIT: begin
                if (r_stb) begin
                    ext_shift_s = 1'b1;
                    if (ext_cnt_r == 2'd3) begin
                        state_nxt = ST_FINISH;
                    end else begin
                        state_nxt   = ST_EXT;
                        ext_cnt_nxt = ext_cnt_r + 2'd1;
                    end
                end else begin
                    state_nxt = ST_EXT_WAIT;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase

        w_stb_nxt = (state_nxt == ST_SEND) || (state_nxt == ST_POLL) || (state_nxt == ST_EXT);
        if (state_nxt == ST_SEND) begin
            w_data_nxt = frame_byte(byte_idx_nxt, cmd_idx_r, cmd_arg_r, crc_r);
        end else begin
            w_data_nxt = 8'hFF;
        end
    end

    // Command latch, CRC register and sequencing counters.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            cmd_idx_r  <= 6'd0;
            cmd_arg_r  <= 32'd0;
            cmd_long_r <= 1'b0;
            crc_r      <= 7'd0;
            byte_idx_r <= 3'd0;
            poll_cnt_r <= 8'd0;
            ext_cnt_r  <= 2'd0;
        end else begin
            byte_idx_r <= byte_idx_nxt;
            poll_cnt_r <= poll_cnt_nxt;
            ext_cnt_r  <= ext_cnt_nxt;
            if (accept_s) begin
                cmd_idx_r  <= cmd_idx;
                cmd_arg_r  <= cmd_arg;
                cmd_long_r <= cmd_long;
            end
            if (state_r == ST_CALC) begin
                crc_r <= crc7_calc({2'b01, cmd_idx_r, cmd_arg_r});
            end
        end
    end

    // Response capture: R1, R3/R7 payload and timeout flag.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            resp_r1_r  <= 8'hFF;
            resp_ext_r <= 32'd0;
            timeout_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                resp_ext_r <= 32'd0;
                timeout_r  <= 1'b0;
            end
            if (r1_load_s) begin
                resp_r1_r <= r_data;
            end
            if (timeout_set_s) begin
                timeout_r <= 1'b1;
                resp_r1_r <= 8'hFF;
            end
            if (ext_shift_s) begin
                resp_ext_r <= {resp_ext_r[23:0], r_data};
            end
        end
    end

    // Registered handshake and transmit outputs, decoded from the upcoming state.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            w_stb_r  <= 1'b0;
            w_data_r <= 8'hFF;
        end else begin
            busy_r   <= (state_nxt != ST_IDLE);
            done_r   <= (state_nxt == ST_FINISH);
            w_stb_r  <= w_stb_nxt;
            w_data_r <= w_data_nxt;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign timeout  = timeout_r;
    assign resp_r1  = resp_r1_r;
    assign resp_ext = resp_ext_r;
    assign w_stb    = w_stb_r;
    assign w_data   = w_data_r;

endmodule
